// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Bundle of the request, response and ALU-side signals of the
//               shared-ALU arbiter.
//   req_valid/req_ready  per-requester accept handshake (ready is one-hot)
//   req_ain/req_bin      packed 32-bit operands, requester i at [32*i+31:32*i]
//   req_aluop            packed 3-bit ALU ops, requester i at [3*i+2:3*i]
//   alu_ain/bin/op       operands/op towards the single ALU instance
//   alu_out/alu_status   ALU result and status {NEG,OVF,ZERO}
//   rsp_valid/rsp_ready  per-requester result handshake (valid is one-hot)
//   rsp_out/rsp_status   registered result and status
//   slave  modport : arbiter side
//   master modport : requesters + ALU side
// Revision    : 1.0  initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_ain;
  logic [32*NREQ-1:0]   req_bin;
  logic [3*NREQ-1:0]    req_aluop;
  logic [31:0]          alu_ain;
  logic [31:0]          alu_bin;
  logic [2:0]           alu_op;
  logic [31:0]          alu_out;
  logic [2:0]           alu_status;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_out;
  logic [2:0]           rsp_status;

  modport slave (
    input  req_valid, req_ain, req_bin, req_aluop, rsp_ready, alu_out, alu_status,
    output req_ready, rsp_valid, rsp_out, rsp_status, alu_ain, alu_bin, alu_op
  );

  modport master (
    output req_valid, req_ain, req_bin, req_aluop, rsp_ready, alu_out, alu_status,
    input  req_ready, rsp_valid, rsp_out, rsp_status, alu_ain, alu_bin, alu_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one 32-bit ALU between NREQ requesters.
//               Operands are registered on acceptance, the ALU result is
//               registered one cycle later, so the ALU sits between two
//               register stages. FSM: IDLE -> EXEC -> RESP -> IDLE.
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   bus       alu_share_arbiter_if.slave (request/response/ALU signals)
//   busy      high in EXEC or RESP
//   grant_id  index of the current owner (meaningful while busy)
// Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter  int NREQ = 4,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [GW-1:0]   last_grant;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [2:0]      op_code;
  logic [31:0]     res_out;
  logic [2:0]      res_status;

  logic            found;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   cand;
  logic [NREQ-1:0] ready_vec;
  logic [NREQ-1:0] valid_vec;

  // Unpack the flat operand buses so the winner can index them directly.
  logic [31:0] ain_arr [NREQ];
  logic [31:0] bin_arr [NREQ];
  logic [2:0]  op_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ain_arr[i] = bus.req_ain[32*i +: 32];
    assign bin_arr[i] = bus.req_bin[32*i +: 32];
    assign op_arr[i]  = bus.req_aluop[3*i +: 3];
  end

  // Search starts just above the last served requester and wraps, so the
  // most recently served requester is always considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Handshake outputs are forced low while reset is asserted, whatever state
  // the FSM happens to be in before the reset edge.
  always_comb begin
    ready_vec = '0;
    valid_vec = '0;
    if (!reset) begin
      if (state == S_IDLE && found) ready_vec[winner]   = 1'b1;
      if (state == S_RESP)          valid_vec[grant_id] = 1'b1;
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.rsp_valid  = valid_vec;
  assign bus.rsp_out    = res_out;
  assign bus.rsp_status = res_status;

  // The ALU only sees operands during EXEC; it is fed zeros otherwise.
  assign bus.alu_ain = (!reset && state == S_EXEC) ? op_a    : 32'd0;
  assign bus.alu_bin = (!reset && state == S_EXEC) ? op_b    : 32'd0;
  assign bus.alu_op  = (!reset && state == S_EXEC) ? op_code : 3'd0;

  assign busy = !reset && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= GW'(NREQ - 1);
      grant_id   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      res_out    <= '0;
      res_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_a     <= ain_arr[winner];
            op_b     <= bin_arr[winner];
            op_code  <= op_arr[winner];
            grant_id <= winner;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_out    <= bus.alu_out;
          res_status <= bus.alu_status;
          state      <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's rsp_ready completes the transaction.
          if (bus.rsp_ready[grant_id]) begin
            last_grant <= grant_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. Provides a
//               behavioural ALU (ADD=000, XOR=001, OR=010, others -> 0),
//               a table of single operations, and directed sequences for
//               round-robin order, backpressure and reset during RESP.
//               A scoreboard queues the expected result at every accept and
//               compares it at every response handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_BAD = 3'b111;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;
  int         checks = 0;
  int         errors = 0;

  alu_share_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Status {N,V,Z}. V flags any 32-bit wrap of an ADD, signed or unsigned.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        v;
    s = {1'b0, a} + {1'b0, b};
    v = 1'b0;
    case (op)
      OP_ADD: begin
        r = s[31:0];
        v = ((a[31] == b[31]) && (r[31] != a[31])) || s[32];
      end
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      default: r = 32'd0;
    endcase
    return {r, r[31], v, (r == 32'd0)};
  endfunction

  assign {bus.alu_out, bus.alu_status} = alu_model(bus.alu_ain, bus.alu_bin, bus.alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] out;
    logic [2:0]  st;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin : sb_monitor
    logic [34:0] m;
    exp_t        e;
    if (reset) begin
      sbq.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i]) begin
          m     = alu_model(bus.req_ain[32*i +: 32], bus.req_bin[32*i +: 32],
                            bus.req_aluop[3*i +: 3]);
          e.id  = 2'(i);
          e.out = m[34:3];
          e.st  = m[2:0];
          sbq.push_back(e);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_id", 32'(i), 32'(e.id));
            check("sb_out", bus.rsp_out, e.out);
            check("sb_status", 32'(bus.rsp_status), 32'(e.st));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic v);
    bus.req_ain[32*id +: 32] = a;
    bus.req_bin[32*id +: 32] = b;
    bus.req_aluop[3*id +: 3] = op;
    bus.req_valid[id]        = v;
  endtask

  // Waits (bounded) at negedges until any req_ready bit is high.
  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({nm, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, 32'(sbq.size()), 32'd0);
  endtask

  // One complete operation with exact cycle checks; entered and left just
  // after a rising edge.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] eo, input logic [2:0] es,
                       input string nm);
    set_req(id, a, b, op, 1'b1);
    wait_accept(nm);
    check({nm, "_ready"}, 32'(bus.req_ready), 32'd1 << id);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    check({nm, "_exec_busy"}, 32'(busy), 32'd1);
    check({nm, "_exec_gid"}, 32'(grant_id), 32'(id));
    check({nm, "_exec_alu_a"}, bus.alu_ain, a);
    check({nm, "_exec_rspv"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1 << id);
    check({nm, "_rsp_out"}, bus.rsp_out, eo);
    check({nm, "_rsp_status"}, 32'(bus.rsp_status), 32'(es));
    check({nm, "_rsp_alu_idle"}, bus.alu_ain, 32'd0);
    @(posedge clk); #1;
    bus.rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[id] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] eo;
    logic [2:0]  es;
  } vec_t;

  vec_t vt [9];

  initial begin : main
    vt[0] = '{32'd5,        32'd7,        OP_ADD, 32'd12,       3'b000};
    vt[1] = '{32'h7FFFFFFF, 32'd1,        OP_ADD, 32'h80000000, 3'b110};
    vt[2] = '{32'hFFFFFFFF, 32'd1,        OP_ADD, 32'h00000000, 3'b011};
    vt[3] = '{32'hAAAA0000, 32'h0000FFFF, OP_XOR, 32'hAAAAFFFF, 3'b100};
    vt[4] = '{32'h12340000, 32'h00005678, OP_OR,  32'h12345678, 3'b000};
    vt[5] = '{32'hDEADBEEF, 32'h12345678, OP_BAD, 32'h00000000, 3'b001};
    vt[6] = '{32'h00000000, 32'h00000000, OP_ADD, 32'h00000000, 3'b001};
    vt[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_XOR, 32'h00000000, 3'b001};
    vt[8] = '{32'h80000000, 32'h80000000, OP_ADD, 32'h00000000, 3'b011};

    bus.req_valid = '0;
    bus.req_ain   = '0;
    bus.req_bin   = '0;
    bus.req_aluop = '0;
    bus.rsp_ready = '0;
    reset         = 1'b1;

    // Reset state; a pending request must not be acknowledged under reset.
    set_req(0, 32'd1, 32'd1, OP_ADD, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_ain", bus.alu_ain, 32'd0);
    check("rst_rsp_out", bus.rsp_out, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset = 1'b0;

    // Single operations from the table, rotated over requesters.
    for (int i = 0; i < 9; i++) begin
      do_op(i % NREQ, vt[i].a, vt[i].b, vt[i].op, vt[i].eo, vt[i].es, $sformatf("vec%0d", i));
    end

    // Round-robin: all requesters valid continuously, responses always taken.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 * i + 1), 32'(i), OP_ADD, 1'b1);
    bus.rsp_ready = '1;
    for (int g = 0; g < 5; g++) begin
      wait_accept("rr");
      check($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'd1 << (g % NREQ));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain("rr");
    @(posedge clk); #1;
    bus.rsp_ready = '0;

    // Backpressure: response held for 5 cycles, other requesters locked out.
    set_req(1, 32'h11111111, 32'h22222222, OP_ADD, 1'b1);
    wait_accept("bp");
    check("bp_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    set_req(2, 32'd3, 32'd4, OP_ADD, 1'b1);
    set_req(3, 32'd5, 32'd6, OP_OR, 1'b1);
    bus.rsp_ready[0] = 1'b1;
    wait_rsp("bp");
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_valid%0d", c), 32'(bus.rsp_valid), 32'b0010);
      check($sformatf("bp_hold_out%0d", c), bus.rsp_out, 32'h33333333);
      check($sformatf("bp_hold_status%0d", c), 32'(bus.rsp_status), 32'd0);
      check($sformatf("bp_no_accept%0d", c), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 4'b0010;
    drain("bp");
    @(posedge clk); #1;
    bus.rsp_ready = '0;

    // Reset while in RESP discards the op; requester 0 then wins over 2.
    set_req(3, 32'd1, 32'd2, OP_ADD, 1'b1);
    wait_accept("rr3");
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    wait_rsp("rr3");
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(2, 32'h0F0F0F0F, 32'hF0F0F0F0, OP_OR, 1'b1);
    set_req(0, 32'd40, 32'd2, OP_ADD, 1'b1);
    @(negedge clk);
    check("rstresp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstresp_busy", 32'(busy), 32'd0);
    check("rstresp_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstresp_rsp_out", bus.rsp_out, 32'd0);
    check("rstresp_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("rstresp_gid", 32'(grant_id), 32'd0);
    check("rstresp_grant0", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    drain("rstresp");
    @(posedge clk); #1;
    bus.rsp_ready = '0;
    @(negedge clk);
    check("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
